// File: rtl/flash_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : flash_arb_pkg                                               |
// | Desc   : Shared types and constants for the flash read arbiter.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_VGA = 1'b0;
  localparam logic PORT_CPU = 1'b1;

  localparam int                      FLASH_DATA_W = 16;
  localparam logic [FLASH_DATA_W-1:0] ERR_DATA     = '1;

endpackage
`default_nettype wire

// File: rtl/flash_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : flash_arb_pick                                              |
// | Desc   : Combinational winner selection between the VGA and CPU      |
// |          ports. FLASH_ARB_RR_EN selects round-robin (pointer marks   |
// |          the preferred port); otherwise VGA wins every contention.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module flash_arb_pick
  import flash_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic grant_valid,
  output logic grant_id
);

`ifdef FLASH_ARB_RR_EN
  // Contention goes to the preferred port; a lone requester always wins
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ptr;
    end else begin
      grant_id = req1 ? PORT_CPU : PORT_VGA;
    end
  end
`else
  // The pointer has no meaning under fixed priority
  logic unused_ptr;
  assign unused_ptr = ptr;

  // VGA always wins contention; CPU only when it asks alone
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = (req1 && !req0) ? PORT_CPU : PORT_VGA;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/flash_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : flash_arbiter                                               |
// | Desc   : Shares the single-port flash read engine between the VGA    |
// |          fetch port (0) and the CPU/boot port (1). One read per      |
// |          grant, level request/done handshake to the engine, one-     |
// |          cycle ack back to the winner, timeout-bounded accesses.     |
// |          Define FLASH_ARB_RR_EN for round-robin arbitration;         |
// |          default build is fixed priority (VGA first).                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output logic              fl_re,
  output logic [ADDR_W-1:0] fl_addr,
  input  logic [DATA_W-1:0] fl_data,
  input  logic              fl_done
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic              grant_id;
  logic [ADDR_W-1:0] lat_addr;
  logic [CNT_W-1:0]  count;

  logic              pick_valid;
  logic              pick_id;
  logic              rr_ptr;

  flash_arb_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .ptr         (rr_ptr),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

`ifdef FLASH_ARB_RR_EN
  logic rr_ptr_q;

  // After every grant the preference flips to the port that just lost
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= PORT_VGA;
    end else if (state == IDLE && pick_valid) begin
      rr_ptr_q <= ~pick_id;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = PORT_VGA;
`endif

  // Access sequencer: grant, issue to engine, wait with timeout, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rerr     <= 1'b0;
      fl_re    <= 1'b0;
      rdata    <= '0;
      fl_addr  <= '0;
      grant_id <= PORT_VGA;
      lat_addr <= '0;
      count    <= '0;
    end else begin
      // acks are single-cycle: only the WAIT exit raises them
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_id;
            lat_addr <= (pick_id == PORT_CPU) ? addr1 : addr0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          fl_re   <= 1'b1;
          fl_addr <= lat_addr;
          count   <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // a done arriving on the last allowed cycle still counts as data
          if (fl_done) begin
            rdata <= fl_data;
            rerr  <= 1'b0;
            fl_re <= 1'b0;
            ack0  <= (grant_id == PORT_VGA);
            ack1  <= (grant_id == PORT_CPU);
            state <= RESP;
          end else if (count == CNT_LAST) begin
            rdata <= {DATA_W{1'b1}};
            rerr  <= 1'b1;
            fl_re <= 1'b0;
            ack0  <= (grant_id == PORT_VGA);
            ack1  <= (grant_id == PORT_CPU);
            state <= RESP;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
